adc_pattern_gen: RTL and testbench

Parametrised multi-channel synthetic ADC source for bring-up and datapath test without real converters. It is the successor to the fixed 64-bit ADC test block. It produces one packed frame of NUM_CH samples every DIV clocks and supports four selectable patterns. Frames leave through a valid/ready handshake, and drops caused by backpressure are counted. It sits in the 125 MHz domain in place of the ADC capture front end.

---
 rtl/adc_pattern_pkg.sv | 24 ++
 rtl/adc_lfsr32.sv | 31 +++
 rtl/adc_pattern_gen.sv | 161 ++++++++++++++++
 tb/tb_adc_pattern_gen.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pattern_pkg.sv
// Shared types and constants for the synthetic ADC pattern generator.
package adc_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_RAMP   = 2'd0,
    MODE_CONST  = 2'd1,
    MODE_PRBS   = 2'd2,
    MODE_TOGGLE = 2'd3
  } mode_e;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

  // x^32 + x^22 + x^2 + x + 1, Galois form, right shift
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED = 32'h0000_0001;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
  endfunction

endpackage

// File: rtl/adc_lfsr32.sv
// 32-bit Galois LFSR with synchronous reseed; reseed and advance together yield step(seed).
module adc_lfsr32
  import adc_pattern_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_advance,
  input  logic        i_reseed,
  output logic [31:0] o_state
);

  logic [31:0] state_q, state_d;

  always_comb begin
    state_d = i_reseed ? LFSR_SEED : state_q;
    if (i_advance) begin
      state_d = lfsr_step(state_d);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= LFSR_SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign o_state = state_q;

endmodule

// File: rtl/adc_pattern_gen.sv
// Multi-channel synthetic ADC source: one packed frame every DIV clocks, four patterns,
// single-stage valid/ready output with accepted-frame and dropped-frame counters.
module adc_pattern_gen
  import adc_pattern_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned DIV      = 4
) (
  input  logic                         i_125clk,
  input  logic                         i_rst,
  input  logic                         i_enable,
  input  logic [1:0]                   i_mode,
  input  logic [SAMPLE_W-1:0]          i_const,
  input  logic                         i_ready,
  output logic [NUM_CH*SAMPLE_W-1:0]   o_data,
  output logic                         o_valid,
  output logic [31:0]                  o_frame_cnt,
  output logic [15:0]                  o_drop_cnt
);

  localparam int unsigned DIV_W   = $clog2(DIV);
  localparam int unsigned FRAME_W = NUM_CH * SAMPLE_W;

  state_e               state_q, state_d;
  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  mode_e                mode_q, mode_d;
  logic [SAMPLE_W-1:0]  base_q, base_d;
  logic                 phase_q, phase_d;
  logic [FRAME_W-1:0]   data_q, data_d;
  logic                 valid_q, valid_d;
  logic [31:0]          frame_cnt_q, frame_cnt_d;
  logic [15:0]          drop_cnt_q, drop_cnt_d;

  logic                 tick;
  mode_e                mode_in;
  logic                 mode_chg;
  logic [SAMPLE_W-1:0]  base_eff;
  logic                 phase_eff;
  logic [31:0]          lfsr_state;
  logic [31:0]          lfsr_nxt;
  logic                 accept;
  logic [FRAME_W-1:0]   frame;

  assign tick     = (state_q == StRun) && (div_cnt_q == DIV_W'(DIV - 1));
  assign mode_in  = mode_e'(i_mode);
  assign mode_chg = tick && (mode_in != mode_q);
  assign accept   = valid_q && i_ready;

  // A mode switch re-seeds the pattern state before the new frame is formed.
  assign base_eff  = mode_chg ? '0 : base_q;
  assign phase_eff = mode_chg ? 1'b0 : phase_q;
  assign lfsr_nxt  = lfsr_step(mode_chg ? LFSR_SEED : lfsr_state);

  adc_lfsr32 u_lfsr (
    .i_clk     (i_125clk),
    .i_rst     (i_rst),
    .i_advance (tick && (mode_in == MODE_PRBS)),
    .i_reseed  (mode_chg),
    .o_state   (lfsr_state)
  );

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    localparam logic [SAMPLE_W-1:0] K = SAMPLE_W'(k);
    logic [SAMPLE_W-1:0] sample;

    always_comb begin
      sample = '0;
      unique case (mode_in)
        MODE_RAMP:   sample = base_eff + K;
        MODE_CONST:  sample = i_const;
        MODE_PRBS:   sample = lfsr_nxt[SAMPLE_W-1:0] ^ K;
        MODE_TOGGLE: sample = {SAMPLE_W{phase_eff ^ K[0]}};
        default:     sample = '0;
      endcase
    end

    assign frame[k*SAMPLE_W +: SAMPLE_W] = sample;
  end

  always_comb begin
    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    mode_d      = mode_q;
    base_d      = base_q;
    phase_d     = phase_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (i_enable) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (!i_enable) begin
          state_d   = StIdle;
          div_cnt_d = '0;
        end else begin
          div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Pattern state advances on every tick, dropped or not.
    if (tick) begin
      mode_d  = mode_in;
      base_d  = (mode_in == MODE_RAMP) ? base_eff + SAMPLE_W'(1) : base_eff;
      phase_d = (mode_in == MODE_TOGGLE) ? ~phase_eff : phase_eff;
    end

    if (accept) begin
      frame_cnt_d = frame_cnt_q + 32'd1;
    end

    if (tick) begin
      if (!valid_q || i_ready) begin
        data_d  = frame;
        valid_d = 1'b1;
      end else if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end else if (accept) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_125clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= StIdle;
      div_cnt_q   <= '0;
      mode_q      <= MODE_RAMP;
      base_q      <= '0;
      phase_q     <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      mode_q      <= mode_d;
      base_q      <= base_d;
      phase_q     <= phase_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_cnt = frame_cnt_q;
  assign o_drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_adc_pattern_gen.sv
// Scoreboard bench: a reference model queues every frame that should load; a monitor
// compares presented frames, valid and both counters against it.
module tb_adc_pattern_gen;

  localparam int NCH = 4;
  localparam int SW  = 16;
  localparam int DV  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [15:0]   cst = 16'h0;
  logic          ready = 1'b1;
  logic [63:0]   o_data;
  logic          o_valid;
  logic [31:0]   o_frame_cnt;
  logic [15:0]   o_drop_cnt;

  int tests = 0;
  int fails = 0;

  // Reference model state
  bit          m_run;
  int          m_div;
  int          m_mode;
  int          m_base;
  logic [31:0] m_lfsr;
  bit          m_phase;
  bit          m_valid;
  logic [31:0] m_frames;
  int          m_drops;
  logic [63:0] exp_q[$];

  adc_pattern_gen #(
    .NUM_CH   (NCH),
    .SAMPLE_W (SW),
    .DIV      (DV)
  ) dut (
    .i_125clk    (clk),
    .i_rst       (rst),
    .i_enable    (en),
    .i_mode      (mode),
    .i_const     (cst),
    .i_ready     (ready),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_frame_cnt (o_frame_cnt),
    .o_drop_cnt  (o_drop_cnt)
  );

  always #4 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    // Polynomial x^32+x^22+x^2+x+1: shift out bit 0, feed it back into taps 31,21,1,0
    logic [31:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ ((32'h1 << 31) | (32'h1 << 21) | (32'h1 << 1) | 32'h1);
    return r;
  endfunction

  function automatic logic [63:0] make_frame(input int md, input int base,
                                             input logic [31:0] lf, input bit ph,
                                             input logic [15:0] c);
    logic [63:0] f;
    logic [15:0] s;
    f = '0;
    for (int k = 0; k < NCH; k++) begin
      case (md)
        0:       s = 16'((base + k) % 65536);
        1:       s = c;
        2:       s = lf[15:0] ^ 16'(k);
        default: s = ((ph ? 1 : 0) != (k % 2)) ? 16'hFFFF : 16'h0000;
      endcase
      f[k*16 +: 16] = s;
    end
    return f;
  endfunction

  task automatic model_reset();
    m_run = 0; m_div = 0; m_mode = 0; m_base = 0; m_lfsr = 32'h1; m_phase = 0;
    m_valid = 0; m_frames = 0; m_drops = 0;
    exp_q.delete();
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    bit tick;
    bit acc;
    logic [63:0] frm;
    tick = m_run && (m_div == DV - 1);
    acc  = m_valid && ready;
    if (acc) m_frames = m_frames + 1;
    if (tick) begin
      if (int'(mode) != m_mode) begin
        m_base = 0; m_lfsr = 32'h1; m_phase = 0;
      end
      m_mode = int'(mode);
      if (m_mode == 2) m_lfsr = lfsr_next(m_lfsr);
      frm = make_frame(m_mode, m_base, m_lfsr, m_phase, cst);
      if (m_mode == 0) m_base = (m_base + 1) % 65536;
      if (m_mode == 3) m_phase = ~m_phase;
      if (!m_valid || ready) begin
        exp_q.push_back(frm);
        m_valid = 1;
      end else if (m_drops < 65535) begin
        m_drops++;
      end
    end else if (acc) begin
      m_valid = 0;
    end
    if (m_run) begin
      if (!en) begin
        m_run = 0; m_div = 0;
      end else begin
        m_div = tick ? 0 : m_div + 1;
      end
    end else if (en) begin
      m_run = 1;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!rst) model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    model_reset();
    #1;
    check("reset_data", o_data, 64'h0);
    check("reset_valid", {63'h0, o_valid}, 64'h0);
    check("reset_frame_cnt", {32'h0, o_frame_cnt}, 64'h0);
    check("reset_drop_cnt", {48'h0, o_drop_cnt}, 64'h0);
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  // Cycles until o_valid is seen, bounded; returns -1 on timeout.
  task automatic wait_valid(output int n);
    n = -1;
    for (int i = 1; i <= 50; i++) begin
      cyc();
      if (o_valid) begin
        n = i;
        break;
      end
    end
    if (n < 0) check("wait_valid_timeout", 64'h0, 64'h1);
  endtask

  // Monitor: compares everything the DUT presents against the model.
  always @(negedge clk) begin
    if (!rst) begin
      check("valid", {63'h0, o_valid}, {63'h0, m_valid});
      check("frame_cnt", {32'h0, o_frame_cnt}, {32'h0, m_frames});
      check("drop_cnt", {48'h0, o_drop_cnt}, 64'(m_drops));
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          check("frame_available", 64'h0, 64'h1);
        end else begin
          check("data", o_data, exp_q[0]);
          if (ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int n;
    model_reset();

    // RAMP: latency and first two frames
    do_reset();
    mode = 2'd0; ready = 1'b1; en = 1'b1;
    cyc();
    wait_valid(n);
    check("ramp_latency", 64'(n), 64'(DV));
    check("ramp_frame0", o_data, 64'h0003_0002_0001_0000);
    repeat (DV) cyc();
    check("ramp_frame1", o_data, 64'h0004_0003_0002_0001);
    cyc();
    check("ramp_frame_cnt", {32'h0, o_frame_cnt}, 64'd2);

    // CONST: value and single-cycle valid pulse
    do_reset();
    mode = 2'd1; cst = 16'hA5A5; ready = 1'b1; en = 1'b1;
    cyc();
    wait_valid(n);
    check("const_frame", o_data, 64'hA5A5_A5A5_A5A5_A5A5);
    cyc();
    check("const_valid_pulse", {63'h0, o_valid}, 64'h0);

    // PRBS from reset
    do_reset();
    mode = 2'd2; en = 1'b1;
    cyc();
    wait_valid(n);
    check("prbs_frame0", o_data, 64'h0000_0001_0002_0003);

    // TOGGLE alternation
    do_reset();
    mode = 2'd3; en = 1'b1;
    cyc();
    wait_valid(n);
    check("toggle_frame0", o_data, 64'hFFFF_0000_FFFF_0000);
    repeat (DV) cyc();
    check("toggle_frame1", o_data, 64'h0000_FFFF_0000_FFFF);

    // Backpressure: 10 ticks with ready low, then ready on the 11th tick edge
    do_reset();
    mode = 2'd0; ready = 1'b0; en = 1'b1;
    cyc();
    repeat (10 * DV) cyc();
    check("bp_held", o_data, 64'h0003_0002_0001_0000);
    check("bp_drops", {48'h0, o_drop_cnt}, 64'd9);
    repeat (DV - 1) cyc();
    ready = 1'b1;
    cyc();
    check("bp_no_bubble", o_data, 64'h000D_000C_000B_000A);
    check("bp_valid", {63'h0, o_valid}, 64'h1);
    check("bp_frame_cnt", {32'h0, o_frame_cnt}, 64'd1);

    // Reset mid-run with a frame pending, then RAMP restarts from base 0
    do_reset();
    mode = 2'd0; ready = 1'b1; en = 1'b1;
    cyc();
    wait_valid(n);
    check("post_reset_frame0", o_data, 64'h0003_0002_0001_0000);

    // Randomized run: backpressure, mode switches, enable toggles
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) < 3) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 2) cst = 16'($urandom);
      if (en && $urandom_range(0, 199) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 9) == 0) en = 1'b1;
      cyc();
    end

    // Long stall to reach drop saturation is impractical; sweep a shorter stall instead
    ready = 1'b0; en = 1'b1;
    repeat (20 * DV) cyc();
    ready = 1'b1;
    repeat (3 * DV) cyc();

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
